// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-channel cache-line memory arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin (see rr_pick).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int DEF_ADDR_W = 28;
   localparam int DEF_LINE_W = 128;
   localparam int MAX_CH     = 8;
   localparam int IDX_W      = 3;

   // First requester at or after ptr, wrapping modulo n_ch.
   function automatic logic [IDX_W-1:0] pick_rr(input logic [MAX_CH-1:0] req,
                                                input logic [IDX_W-1:0]  ptr,
                                                input int                n_ch);
      logic [IDX_W-1:0] sel;
      logic             found;
      int               j;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_CH; k++) begin
         j = (int'(ptr) + k) % n_ch;
         if (k < n_ch && !found && req[j[IDX_W-1:0]]) begin
            sel   = j[IDX_W-1:0];
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational grant picker: request vector and pointer in, one-hot grant
// and index out. With MEM_ARB_FIXED_PRIO_EN defined the pointer is ignored
// and the lowest requesting index wins.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int N_CH = 2
) (
   input  logic [N_CH-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_CH-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Lowest index wins; scan downward so the last hit is the smallest.
   always_comb begin
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end
`else
   logic [MAX_CH-1:0] req_ext;

   // Round-robin: first requester at or after the pointer.
   always_comb begin
      req_ext             = '0;
      req_ext[N_CH-1:0]   = req;
      idx                 = pick_rr(req_ext, ptr, N_CH);
   end
`endif

   // One-hot form of the chosen index, qualified by any request.
   always_comb begin
      any = |req;
      gnt = '0;
      for (int i = 0; i < N_CH; i++) begin
         gnt[i] = any && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel cache-line arbiter onto a single slow-memory port.
// Registered grant and response; one idle memory cycle between transactions.
// Build option: MEM_ARB_FIXED_PRIO_EN removes the round-robin pointer and
// gives fixed lowest-index priority; ports and timing are unchanged.
//
// state | meaning
// IDLE  | arbitrate; latch winner, address and data, launch memory strobe
// BUSY  | hold memory strobe/address/data until mem_ready
// RESP  | ch_ready pulse for the served channel; no arbitration
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_CH   = 2,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
) (
   input  logic                     clk,
   input  logic                     proc_reset,
   input  logic [N_CH-1:0]          ch_read,
   input  logic [N_CH-1:0]          ch_write,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr,
   input  logic [N_CH*LINE_W-1:0]   ch_wdata,
   output logic [LINE_W-1:0]        ch_rdata,
   output logic [N_CH-1:0]          ch_ready,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [LINE_W-1:0]        mem_wdata,
   input  logic [LINE_W-1:0]        mem_rdata,
   input  logic                     mem_ready
);

   arb_state_t       state;
   logic [IDX_W-1:0] g;
   logic [IDX_W-1:0] ptr;
   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  pick_gnt;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [ADDR_W-1:0] sel_addr;
   logic [LINE_W-1:0] sel_wdata;
   logic             sel_write;
   logic [N_CH-1:0]  g_onehot;
   logic [IDX_W-1:0] ptr_next;

   assign req = ch_read | ch_write;

   rr_pick #(.N_CH(N_CH)) u_pick (
      .req (req),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Mux the winning channel's address, data and direction (write wins).
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (pick_gnt[i]) begin
            sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
            sel_write = ch_write[i];
         end
      end
   end

   // Served channel as one-hot, and the pointer value that follows it.
   always_comb begin
      g_onehot = '0;
      for (int i = 0; i < N_CH; i++) begin
         g_onehot[i] = (g == IDX_W'(i));
      end
      ptr_next = (g == IDX_W'(N_CH - 1)) ? '0 : g + 1'b1;
   end

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`endif

   // Arbitration FSM with registered memory-side and channel-side outputs.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state     <= IDLE;
         g         <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ch_rdata  <= '0;
         ch_ready  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         ptr       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ch_ready <= '0;
               if (pick_any) begin
                  g         <= pick_idx;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_write <= sel_write;
                  mem_read  <= ~sel_write;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  if (mem_read) ch_rdata <= mem_rdata;
                  ch_ready  <= g_onehot;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                  ptr       <= ptr_next;
`endif
                  state     <= RESP;
               end
            end
            RESP: begin
               ch_ready <= '0;
               state    <= IDLE;
            end
            default: begin
               ch_ready <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic unused_ptr_next;
   assign unused_ptr_next = ^ptr_next;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default round-robin build, N_CH = 2).
module tb_mem_arbiter;

   localparam int N_CH   = 2;
   localparam int ADDR_W = 28;
   localparam int LINE_W = 128;

   logic                   clk;
   logic                   proc_reset;
   logic [N_CH-1:0]        ch_read;
   logic [N_CH-1:0]        ch_write;
   logic [N_CH*ADDR_W-1:0] ch_addr;
   logic [N_CH*LINE_W-1:0] ch_wdata;
   logic [LINE_W-1:0]      ch_rdata;
   logic [N_CH-1:0]        ch_ready;
   logic                   mem_read;
   logic                   mem_write;
   logic [ADDR_W-1:0]      mem_addr;
   logic [LINE_W-1:0]      mem_wdata;
   logic [LINE_W-1:0]      mem_rdata;
   logic                   mem_ready;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   localparam logic [LINE_W-1:0] RD_A5 = {16{8'hA5}};
   localparam logic [LINE_W-1:0] RD_C1 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
   localparam logic [LINE_W-1:0] RD_C2 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;

   mem_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk        (clk),
      .proc_reset (proc_reset),
      .ch_read    (ch_read),
      .ch_write   (ch_write),
      .ch_addr    (ch_addr),
      .ch_wdata   (ch_wdata),
      .ch_rdata   (ch_rdata),
      .ch_ready   (ch_ready),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory takes n_wait cycles, then returns rdata with a one-cycle mem_ready.
   task automatic mem_respond(input int n_wait, input logic [LINE_W-1:0] rdata);
      for (int i = 0; i < n_wait; i++) step();
      mem_ready = 1'b1;
      mem_rdata = rdata;
      step();
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      proc_reset = 1'b1;
      ch_read    = '0;
      ch_write   = '0;
      ch_addr    = '0;
      ch_wdata   = '0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
      step();
      step();
      chk("rst_mem_read",  128'(mem_read),  128'd0);
      chk("rst_mem_write", 128'(mem_write), 128'd0);
      chk("rst_ch_ready",  128'(ch_ready),  128'd0);
      chk("rst_ch_rdata",  ch_rdata,        128'd0);
      chk("rst_mem_addr",  128'(mem_addr),  128'd0);
      proc_reset = 1'b0;
      step();

      // mem_ready in IDLE is ignored
      mem_ready = 1'b1;
      mem_rdata = 128'hBAD;
      step();
      mem_ready = 1'b0;
      step();
      chk("idle_ready_ign", 128'(ch_ready), 128'd0);
      chk("idle_rdata_ign", ch_rdata, 128'd0);

      // single read on ch0
      ch_read = 2'b01;
      ch_addr[0*ADDR_W +: ADDR_W] = 28'h0000010;
      step();
      chk("rd_mem_read",  128'(mem_read),  128'd1);
      chk("rd_mem_write", 128'(mem_write), 128'd0);
      chk("rd_mem_addr",  128'(mem_addr),  128'h0000010);
      step();
      chk("rd_hold_read",  128'(mem_read), 128'd1);
      chk("rd_no_ready",   128'(ch_ready), 128'd0);
      mem_respond(2, RD_A5);
      chk("rd_ch_ready",  128'(ch_ready), 128'b01);
      chk("rd_ch_rdata",  ch_rdata, RD_A5);
      chk("rd_strobe_off", 128'(mem_read), 128'd0);
      ch_read = '0;
      step();
      chk("rd_ready_pulse", 128'(ch_ready), 128'd0);
      chk("rd_rdata_hold",  ch_rdata, RD_A5);

      // write on ch1 (pointer now 1)
      ch_write = 2'b10;
      ch_addr[1*ADDR_W +: ADDR_W]  = 28'hFFFFFFF;
      ch_wdata[1*LINE_W +: LINE_W] = 128'h1;
      step();
      chk("wr_mem_write", 128'(mem_write), 128'd1);
      chk("wr_mem_read",  128'(mem_read),  128'd0);
      chk("wr_mem_addr",  128'(mem_addr),  128'hFFFFFFF);
      chk("wr_mem_wdata", mem_wdata, 128'h1);
      mem_respond(1, 128'hDEAD);
      chk("wr_ch_ready",  128'(ch_ready), 128'b10);
      chk("wr_rdata_kept", ch_rdata, RD_A5);
      chk("wr_strobe_off", 128'(mem_write), 128'd0);
      ch_write = '0;
      step();

      // contention, pointer now 0: ch0 first, then ch1
      ch_read = 2'b11;
      ch_addr[0*ADDR_W +: ADDR_W] = 28'h0000100;
      ch_addr[1*ADDR_W +: ADDR_W] = 28'h0000200;
      step();
      chk("ct1_addr_ch0", 128'(mem_addr), 128'h0000100);
      mem_respond(1, RD_C1);
      chk("ct1_ready_ch0", 128'(ch_ready), 128'b01);
      chk("ct1_rdata", ch_rdata, RD_C1);
      ch_read = 2'b10;
      step();
      chk("ct1_gap_read", 128'(mem_read), 128'd0);
      step();
      chk("ct1_ch1_read", 128'(mem_read), 128'd1);
      chk("ct1_addr_ch1", 128'(mem_addr), 128'h0000200);
      mem_respond(0, RD_C2);
      chk("ct1_ready_ch1", 128'(ch_ready), 128'b10);
      chk("ct1_rdata_ch1", ch_rdata, RD_C2);
      ch_read = '0;
      step();
      // second contention: pointer wrapped to 0, ch0 first again
      ch_read = 2'b11;
      step();
      chk("ct2_addr_ch0", 128'(mem_addr), 128'h0000100);
      mem_respond(0, RD_C1);
      chk("ct2_ready_ch0", 128'(ch_ready), 128'b01);
      ch_read = 2'b10;
      step();
      step();
      chk("ct2_addr_ch1", 128'(mem_addr), 128'h0000200);
      mem_respond(0, RD_C2);
      chk("ct2_ready_ch1", 128'(ch_ready), 128'b10);
      ch_read = '0;
      step();

      // read+write on ch0: write first, read afterwards
      ch_read  = 2'b01;
      ch_write = 2'b01;
      ch_addr[0*ADDR_W +: ADDR_W]  = 28'h0000300;
      ch_wdata[0*LINE_W +: LINE_W] = 128'h55;
      step();
      chk("rw_mem_write", 128'(mem_write), 128'd1);
      chk("rw_mem_read",  128'(mem_read),  128'd0);
      chk("rw_wdata",     mem_wdata, 128'h55);
      mem_respond(1, 128'hBEEF);
      chk("rw_ready_wr", 128'(ch_ready), 128'b01);
      chk("rw_rdata_kept", ch_rdata, RD_C2);
      ch_write = '0;
      step();
      step();
      chk("rw_mem_read2",  128'(mem_read),  128'd1);
      chk("rw_mem_write2", 128'(mem_write), 128'd0);
      chk("rw_addr2",      128'(mem_addr),  128'h0000300);
      mem_respond(1, 128'h77);
      chk("rw_ready_rd", 128'(ch_ready), 128'b01);
      chk("rw_rdata",    ch_rdata, 128'h77);
      ch_read = '0;
      step();

      // reset mid-BUSY (pointer is 1 beforehand)
      ch_read = 2'b10;
      ch_addr[1*ADDR_W +: ADDR_W] = 28'h0000400;
      step();
      chk("rb_mem_read", 128'(mem_read), 128'd1);
      step();
      #2;
      proc_reset = 1'b1;
      #1;
      chk("rb_async_read",  128'(mem_read), 128'd0);
      chk("rb_async_ready", 128'(ch_ready), 128'd0);
      chk("rb_async_rdata", ch_rdata, 128'd0);
      step();
      proc_reset = 1'b0;
      ch_read = 2'b11;
      ch_addr[0*ADDR_W +: ADDR_W] = 28'h0000500;
      step();
      chk("rb_ptr0_addr", 128'(mem_addr), 128'h0000500);
      mem_respond(0, RD_C1);
      chk("rb_ready_ch0", 128'(ch_ready), 128'b01);
      ch_read = 2'b10;
      step();
      step();
      chk("rb_ch1_addr", 128'(mem_addr), 128'h0000400);
      mem_respond(0, RD_C2);
      chk("rb_ready_ch1", 128'(ch_ready), 128'b10);
      ch_read = '0;
      step();
      chk("end_idle_read", 128'(mem_read), 128'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-channel arbiter that merges several cache-line memory requesters (I-cache, D-cache, future prefetch/DMA) onto one slow-memory port.
- Uses the same line-granular read/write/ready handshake as the caches' memory side.
- Sits between the cache instances and the single external memory interface, enabling a one-memory-port variant of the chip top.
- Arbitration is round-robin, with registered grant and response.

Parameters:
- N_CH, 2, number of requester channels (2..8).
- ADDR_W, 28, line address width (byte address bits [31:4]).
- LINE_W, 128, cache line width in bits.

Ports:
- clk  input  1  clock.
- proc_reset  input  1  asynchronous, active-high reset.
- ch_read  input  N_CH  per-channel line read request.
- ch_write  input  N_CH  per-channel line write request.
- ch_addr  input  N_CH*ADDR_W  per-channel line address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- ch_wdata  input  N_CH*LINE_W  per-channel write line; channel i occupies bits [i*LINE_W +: LINE_W].
- ch_rdata  output  LINE_W  read line, broadcast to all channels; valid only with that channel's ch_ready.
- ch_ready  output  N_CH  one-hot, single-cycle completion pulse.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory line address.
- mem_wdata  output  LINE_W  memory write line.
- mem_rdata  input  LINE_W  memory read line.
- mem_ready  input  1  memory completion pulse.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous and active-high on proc_reset.
  - On reset: all outputs 0, state IDLE, round-robin pointer 0.
  - Reset mid-transaction abandons the transaction immediately; memory strobes drop asynchronously.
- Requester protocol: a requester holds read/write and address/data stable until its ch_ready pulse, then deasserts within the same cycle.
- Memory protocol:
  - mem_read/mem_write stay asserted with stable mem_addr/mem_wdata until mem_ready is sampled high.
  - mem_ready is one cycle wide.
- FSM states IDLE, BUSY, RESP:
  - IDLE:
    - If any channel requests, pick channel g = first requester at or after the pointer (modulo N_CH).
    - Latch g, its address and its wdata; drive mem_read or mem_write from the next cycle; go to BUSY.
    - With no request, stay in IDLE.
  - BUSY:
    - Hold the memory outputs.
    - On mem_ready: register mem_rdata into ch_rdata; pulse ch_ready[g] next cycle; deassert mem strobes in that same cycle; pointer = (g+1) mod N_CH; go to RESP.
  - RESP: ch_ready[g] is high for exactly this cycle; no arbitration occurs; next state is IDLE.
- Latency:
  - Request seen at cycle t → memory strobe at t+1.
  - mem_ready at cycle m → ch_ready at m+1.
  - The earliest next grant is sampled at m+2, so at least one idle memory cycle separates transactions.
- Priority rules:
  - Read and write asserted together on one channel → write serviced; the read stays pending.
  - Simultaneous requests → round-robin; the channel just served has lowest priority next time.
- Channel dropping its request during BUSY: the transaction still completes on memory and ch_ready still pulses. This is an illegal requester behaviour; the arbiter does not abort.
- ch_rdata holds its last value outside RESP. After a write, ch_rdata is unchanged.
- mem_ready while in IDLE or RESP is ignored.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest channel index wins; the pointer register is removed.
- Undefined: round-robin as above.
- Ports and timing are identical in both cases.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, BUSY, RESP).
  - Default ADDR_W and LINE_W constants.
  - Function pick_rr(req, ptr) returning the grant index.
- One natural sub-module: rr_pick. It is combinational: request vector plus pointer in, one-hot grant and index out. The fixed-priority macro is applied inside it.

Test Plan:
- Single read: ch_read=2'b01, ch_addr[0]=28'h0000010, memory ready after 4 cycles with rdata=128'hA5… → mem_read at t+1, mem_addr=28'h0000010, ch_ready=2'b01 one cycle after mem_ready, ch_rdata=128'hA5….
- Contention: both channels read from the same cycle, pointer=0 → ch0 served first and ch1 second. The next contention is ch0 first again, because the pointer wraps to 0 after serving ch1. mem strobe is low for ≥1 cycle between the two transactions.
- Write: ch_write[1]=1, addr 28'hFFFFFFF, wdata=128'h1 → mem_write=1 with mem_wdata=128'h1, ch_ready=2'b10, ch_rdata unchanged.
- Read and write asserted together on ch0 → write issued first; read issued as the next transaction.
- Reset asserted mid-BUSY → mem_read=0 and ch_ready=0 asynchronously; after release, a new ch1 request is granted with pointer 0.
- MEM_ARB_FIXED_PRIO_EN defined, N_CH=4, all channels requesting continuously → ch0 granted every transaction.
